// File: rtl/pkt_rate_meter.sv
// Packet/byte rate meter: counts matching descriptors over a programmable window and reports once per window.
// Optional inter-arrival gap statistics are enabled with `define PKT_GAP_STATS_EN.
module pkt_rate_meter #(
    parameter int C_LENTH_WIDTH   = 16,
    parameter int C_ID_WIDTH      = 16,
    parameter int C_COUNTER_WIDTH = 20,
    parameter int C_PD_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [C_LENTH_WIDTH-1:0]   lenth_Data,
    input  logic [C_ID_WIDTH-1:0]      ID_Data,
    input  logic [C_ID_WIDTH-1:0]      cfg_id,
    input  logic                       cfg_match_all,
    input  logic                       start,
    input  logic [C_COUNTER_WIDTH-1:0] window_clks,
    output logic                       busy,
    output logic                       rpt_valid,
    input  logic                       rpt_ready,
    output logic [C_COUNTER_WIDTH-1:0] rpt_pkts,
    output logic [C_PD_WIDTH-1:0]      rpt_bytes,
    output logic                       rpt_sat
`ifdef PKT_GAP_STATS_EN
    ,
    output logic [C_COUNTER_WIDTH-1:0] rpt_gap_min,
    output logic [C_COUNTER_WIDTH-1:0] rpt_gap_max
`endif
);

    // state   | meaning
    // IDLE    | waiting for start with a non-zero window length
    // RUN     | window open, timer counting down, matches accumulated
    // REPORT  | report record held on rpt_* until rpt_ready

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [C_COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_COUNTER_WIDTH-1:0] CNT_ONE = {{(C_COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_PD_WIDTH-1:0]      PD_MAX  = '1;
    // Sum width covers both operands so a length wider than the accumulator is never truncated.
    localparam int SUM_W = ((C_PD_WIDTH > C_LENTH_WIDTH) ? C_PD_WIDTH : C_LENTH_WIDTH) + 1;

    state_t state, state_nxt;

    logic [C_COUNTER_WIDTH-1:0] timer;
    logic [C_COUNTER_WIDTH-1:0] pkts, pkts_nxt;
    logic [C_PD_WIDTH-1:0]      bytes, bytes_nxt;
    logic                       sat, sat_nxt;
    logic [SUM_W-1:0]           sum_wide;
    logic                       match, run_match, start_ok, last_cycle;

    assign match      = valid & (cfg_match_all | (ID_Data == cfg_id));
    assign run_match  = (state == S_RUN) & match;
    assign start_ok   = (state == S_IDLE) & start & (window_clks != '0);
    assign last_cycle = (state == S_RUN) & (timer == CNT_ONE);
    assign sum_wide   = SUM_W'(bytes) + SUM_W'(lenth_Data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok)   state_nxt = S_RUN;
            S_RUN:    if (last_cycle) state_nxt = S_REPORT;
            S_REPORT: if (rpt_ready)  state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        rpt_valid = (state == S_REPORT);
    end

    always_comb begin
        pkts_nxt  = pkts;
        bytes_nxt = bytes;
        sat_nxt   = sat;
        if (run_match) begin
            if (pkts != CNT_MAX) begin
                pkts_nxt = pkts + CNT_ONE;
            end
            if (sum_wide > SUM_W'(PD_MAX)) begin
                bytes_nxt = PD_MAX;
            end else begin
                bytes_nxt = sum_wide[C_PD_WIDTH-1:0];
            end
            // A counter sitting at all-ones counts as saturated.
            if ((pkts_nxt == CNT_MAX) || (bytes_nxt == PD_MAX)) begin
                sat_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            pkts      <= '0;
            bytes     <= '0;
            sat       <= 1'b0;
            rpt_pkts  <= '0;
            rpt_bytes <= '0;
            rpt_sat   <= 1'b0;
        end else begin
            if (start_ok) begin
                timer <= window_clks;
                pkts  <= '0;
                bytes <= '0;
                sat   <= 1'b0;
            end else if (state == S_RUN) begin
                timer <= timer - CNT_ONE;
                pkts  <= pkts_nxt;
                bytes <= bytes_nxt;
                sat   <= sat_nxt;
            end
            if (last_cycle) begin
                rpt_pkts  <= pkts_nxt;
                rpt_bytes <= bytes_nxt;
                rpt_sat   <= sat_nxt;
            end
        end
    end

`ifdef PKT_GAP_STATS_EN
    logic [C_COUNTER_WIDTH-1:0] gap_cnt, gap_meas;
    logic [C_COUNTER_WIDTH-1:0] gap_min, gap_min_nxt, gap_max, gap_max_nxt;
    logic                       gap_armed, gap_seen, gap_seen_nxt;

    assign gap_meas = (gap_cnt == CNT_MAX) ? CNT_MAX : (gap_cnt + CNT_ONE);

    always_comb begin
        gap_min_nxt  = gap_min;
        gap_max_nxt  = gap_max;
        gap_seen_nxt = gap_seen;
        if (run_match && gap_armed) begin
            gap_seen_nxt = 1'b1;
            if (gap_meas < gap_min) gap_min_nxt = gap_meas;
            if (gap_meas > gap_max) gap_max_nxt = gap_meas;
        end
    end

    // The first match of a window only arms the counter; later matches close a gap and restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt     <= '0;
            gap_armed   <= 1'b0;
            gap_seen    <= 1'b0;
            gap_min     <= '0;
            gap_max     <= '0;
            rpt_gap_min <= '0;
            rpt_gap_max <= '0;
        end else begin
            if (start_ok) begin
                gap_cnt   <= '0;
                gap_armed <= 1'b0;
                gap_seen  <= 1'b0;
                gap_min   <= CNT_MAX;
                gap_max   <= '0;
            end else if (state == S_RUN) begin
                gap_min  <= gap_min_nxt;
                gap_max  <= gap_max_nxt;
                gap_seen <= gap_seen_nxt;
                if (run_match) begin
                    gap_cnt   <= '0;
                    gap_armed <= 1'b1;
                end else if (gap_armed) begin
                    gap_cnt <= gap_meas;
                end
            end
            if (last_cycle) begin
                rpt_gap_min <= gap_seen_nxt ? gap_min_nxt : '0;
                rpt_gap_max <= gap_seen_nxt ? gap_max_nxt : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_rate_meter.sv
// Scoreboard bench for pkt_rate_meter: a wide instance and a narrow (saturating) instance share the traffic.
module tb_pkt_rate_meter;

    localparam int CW  = 20;
    localparam int PW  = 32;
    localparam int SCW = 3;
    localparam int SPW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [15:0]   lenth_Data, ID_Data, cfg_id;
    logic          cfg_match_all;
    logic          start_m, start_s;
    logic [CW-1:0] window_clks;
    logic          rpt_ready;

    logic           m_busy, m_valid, m_sat;
    logic [CW-1:0]  m_pkts;
    logic [PW-1:0]  m_bytes;
    logic           s_busy, s_valid, s_sat;
    logic [SCW-1:0] s_pkts;
    logic [SPW-1:0] s_bytes;
`ifdef PKT_GAP_STATS_EN
    logic [CW-1:0]  m_gmin, m_gmax;
    logic [SCW-1:0] s_gmin, s_gmax;
`endif

    typedef struct {
        longint unsigned pkts;
        longint unsigned bytes;
        bit              sat;
        longint unsigned gmin;
        longint unsigned gmax;
    } rec_t;

    rec_t q_m[$];
    rec_t q_s[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pkt_rate_meter #(.C_LENTH_WIDTH(16), .C_ID_WIDTH(16), .C_COUNTER_WIDTH(CW), .C_PD_WIDTH(PW)) u_dut (
        .clk(clk), .reset(reset), .valid(valid), .lenth_Data(lenth_Data), .ID_Data(ID_Data),
        .cfg_id(cfg_id), .cfg_match_all(cfg_match_all), .start(start_m), .window_clks(window_clks),
        .busy(m_busy), .rpt_valid(m_valid), .rpt_ready(rpt_ready), .rpt_pkts(m_pkts),
        .rpt_bytes(m_bytes), .rpt_sat(m_sat)
`ifdef PKT_GAP_STATS_EN
        , .rpt_gap_min(m_gmin), .rpt_gap_max(m_gmax)
`endif
    );

    pkt_rate_meter #(.C_LENTH_WIDTH(16), .C_ID_WIDTH(16), .C_COUNTER_WIDTH(SCW), .C_PD_WIDTH(SPW)) u_dut_s (
        .clk(clk), .reset(reset), .valid(valid), .lenth_Data(lenth_Data), .ID_Data(ID_Data),
        .cfg_id(cfg_id), .cfg_match_all(cfg_match_all), .start(start_s), .window_clks(window_clks[SCW-1:0]),
        .busy(s_busy), .rpt_valid(s_valid), .rpt_ready(rpt_ready), .rpt_pkts(s_pkts),
        .rpt_bytes(s_bytes), .rpt_sat(s_sat)
`ifdef PKT_GAP_STATS_EN
        , .rpt_gap_min(s_gmin), .rpt_gap_max(s_gmax)
`endif
    );

    function automatic void chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare every presented report against the head of the queue, pop on handshake.
    always @(negedge clk) begin
        if (!reset && m_valid) begin
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_unexpected_report: rpt_valid=1, expected 0");
            end else begin
                chk("m_pkts", m_pkts, q_m[0].pkts);
                chk("m_bytes", m_bytes, q_m[0].bytes);
                chk("m_sat", m_sat, q_m[0].sat);
`ifdef PKT_GAP_STATS_EN
                chk("m_gap_min", m_gmin, q_m[0].gmin);
                chk("m_gap_max", m_gmax, q_m[0].gmax);
`endif
                if (rpt_ready) void'(q_m.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && s_valid) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_report: rpt_valid=1, expected 0");
            end else begin
                chk("s_pkts", s_pkts, q_s[0].pkts);
                chk("s_bytes", s_bytes, q_s[0].bytes);
                chk("s_sat", s_sat, q_s[0].sat);
`ifdef PKT_GAP_STATS_EN
                chk("s_gap_min", s_gmin, q_s[0].gmin);
                chk("s_gap_max", s_gmax, q_s[0].gmax);
`endif
                if (rpt_ready) void'(q_s.pop_front());
            end
        end
    end

    // One full window: start, w cycles of traffic, report held for `hold` cycles, then accepted.
    // period>0: one descriptor every `period` cycles from the first window cycle; 0: random.
    // fix_id/fix_len < 0 select random IDs (matching or not) / random lengths.
    task automatic run_window(input bit sml, input int w, input int period,
                              input int fix_id, input int fix_len, input int hold);
        longint unsigned cnt = 0, sum = 0, cmax, pmax, gmin, gmax, d;
        int    prev = -1;
        int    ngap = 0;
        bit    v, m;
        logic [15:0] idv, lv;
        rec_t  r;
        cmax = sml ? ((64'd1 << SCW) - 1) : ((64'd1 << CW) - 1);
        pmax = sml ? ((64'd1 << SPW) - 1) : ((64'd1 << PW) - 1);
        gmin = cmax;
        gmax = 0;

        window_clks = CW'(w);
        if (sml) start_s = 1'b1; else start_m = 1'b1;
        valid = 1'b1;            // a descriptor on the start cycle itself is outside the window
        ID_Data = cfg_id;
        lenth_Data = 16'd100;
        step();
        start_s = 1'b0;
        start_m = 1'b0;

        for (int k = 1; k <= w; k++) begin
            v   = (period > 0) ? (((k - 1) % period) == 0) : ($urandom_range(0, 1) == 1);
            idv = (fix_id >= 0) ? fix_id[15:0]
                : (($urandom_range(0, 1) == 1) ? cfg_id : cfg_id + 16'($urandom_range(1, 100)));
            lv  = (fix_len >= 0) ? fix_len[15:0] : 16'($urandom_range(0, 65535));
            valid = v;
            ID_Data = idv;
            lenth_Data = lv;
            m = v && (cfg_match_all || (idv == cfg_id));
            if (m) begin
                cnt++;
                sum += lv;
                if (prev >= 0) begin
                    d = longint'(k - prev);
                    if (d > cmax) d = cmax;
                    if (d < gmin) gmin = d;
                    if (d > gmax) gmax = d;
                    ngap++;
                end
                prev = k;
            end
            if (k == 1) chk("busy_in_run", sml ? s_busy : m_busy, 1);
            step();
        end

        r.pkts  = (cnt > cmax) ? cmax : cnt;
        r.bytes = (sum > pmax) ? pmax : sum;
        r.sat   = (cnt >= cmax) || (sum >= pmax);
        r.gmin  = (ngap > 0) ? gmin : 0;
        r.gmax  = (ngap > 0) ? gmax : 0;
        if (sml) q_s.push_back(r); else q_m.push_back(r);

        chk("rpt_valid_latency", sml ? s_valid : m_valid, 1);
        chk("busy_in_report", sml ? s_busy : m_busy, 1);
        for (int h = 0; h < hold; h++) begin
            rpt_ready = 1'b0;
            valid = ($urandom_range(0, 1) == 1);
            ID_Data = cfg_id;
            lenth_Data = 16'($urandom_range(1, 65535));
            window_clks = CW'($urandom_range(1, 7));
            if (sml) start_s = ($urandom_range(0, 3) == 0); else start_m = ($urandom_range(0, 3) == 0);
            step();
            chk("rpt_valid_held", sml ? s_valid : m_valid, 1);
        end
        start_s = 1'b0;
        start_m = 1'b0;
        valid = 1'b0;
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        chk("rpt_valid_drop", sml ? s_valid : m_valid, 0);
        chk("busy_drop", sml ? s_busy : m_busy, 0);
        chk("pkts_hold_idle", sml ? longint'(s_pkts) : longint'(m_pkts), r.pkts);
        step();
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        lenth_Data = '0;
        ID_Data = '0;
        cfg_id = '0;
        cfg_match_all = 1'b0;
        start_m = 1'b0;
        start_s = 1'b0;
        window_clks = '0;
        rpt_ready = 1'b0;
        #12;
        chk("reset_busy", m_busy, 0);
        chk("reset_rpt_valid", m_valid, 0);
        chk("reset_rpt_pkts", m_pkts, 0);
        chk("reset_rpt_bytes", m_bytes, 0);
        chk("reset_rpt_sat", m_sat, 0);
        chk("reset_s_busy", s_busy, 0);
        chk("reset_s_rpt_valid", s_valid, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Generator traffic: 64 B, ID 4, one per 10 clocks, 1000-cycle window
        cfg_id = 16'd4;
        run_window(1'b0, 1000, 10, 4, 64, 2);
        cfg_id = 16'd5;
        run_window(1'b0, 1000, 10, 4, 64, 1);
        cfg_match_all = 1'b1;
        run_window(1'b0, 1000, 10, 4, 64, 0);
        cfg_match_all = 1'b0;
        cfg_id = 16'd4;

        // Consumer stalls 50 cycles with traffic and start pulses
        run_window(1'b0, 200, 0, -1, -1, 50);

        // Single-cycle window and start with zero length
        run_window(1'b0, 1, 1, 4, 1234, 1);
        window_clks = '0;
        start_m = 1'b1;
        step();
        start_m = 1'b0;
        chk("zero_window_busy", m_busy, 0);
        step();
        chk("zero_window_busy2", m_busy, 0);

        for (int i = 0; i < 5; i++) begin
            cfg_id = 16'($urandom_range(0, 65535));
            cfg_match_all = ($urandom_range(0, 3) == 0);
            run_window(1'b0, $urandom_range(2, 80), 0, -1, -1, $urandom_range(0, 6));
        end
        cfg_match_all = 1'b0;
        cfg_id = 16'd4;

        // Narrow instance: packet and byte saturation
        run_window(1'b1, 5, 1, 4, 64, 1);
        run_window(1'b1, 7, 1, 4, 64, 1);
        run_window(1'b1, 6, 1, 4, 250, 1);
        run_window(1'b1, 7, 2, 4, 64, 2);
        for (int i = 0; i < 3; i++) begin
            run_window(1'b1, $urandom_range(1, 7), 0, -1, -1, $urandom_range(0, 3));
        end

        // Reset halfway through a 1000-cycle window
        window_clks = CW'(1000);
        start_m = 1'b1;
        step();
        start_m = 1'b0;
        for (int k = 1; k < 500; k++) begin
            valid = (((k - 1) % 10) == 0);
            ID_Data = cfg_id;
            lenth_Data = 16'd64;
            step();
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", m_busy, 0);
        chk("abort_rpt_valid", m_valid, 0);
        chk("abort_rpt_pkts", m_pkts, 0);
        chk("abort_rpt_bytes", m_bytes, 0);
        chk("abort_rpt_sat", m_sat, 0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 600; k++) begin
            valid = ($urandom_range(0, 1) == 1);
            ID_Data = cfg_id;
            step();
        end
        valid = 1'b0;
        chk("abort_stays_idle", m_busy, 0);
        run_window(1'b0, 30, 3, 4, 64, 1);

        chk("m_queue_drained", q_m.size(), 0);
        chk("s_queue_drained", q_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
